// File: rtl/rsa_keygen_seq.sv
// Sequential RSA key generator: N = P*Q and D = E^-1 mod (P-1)(Q-1)
// using an extended-Euclid datapath that takes one quotient step per cycle.
module rsa_keygen_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   IN_P,
  input  logic [WIDTH-1:0]   IN_Q,
  input  logic [2*WIDTH-1:0] IN_E,
  output logic               busy,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] OUT_N,
  output logic [2*WIDTH-1:0] OUT_D,
  output logic               out_err
);

  localparam int NW = 2 * WIDTH;
  localparam int TW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_FIX
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     p_q, q_q;
  logic [NW-1:0]        e_q, phi_q;
  logic [NW-1:0]        r0_q, r1_q;
  logic signed [TW-1:0] t0_q, t1_q;
  logic                 err_q;
  logic                 arm_q;

  logic                 accept;
  logic                 init_bad;
  logic                 fix_err;
  logic [NW-1:0]        phi_c;
  logic [NW-1:0]        quo;
  logic [NW-1:0]        r_nxt;
  logic signed [TW-1:0] t_nxt;
  logic signed [TW-1:0] d_ext;

  // arm_q blocks a request that coincides with reset release
  assign accept = in_valid && !busy && arm_q;

  always_comb begin
    phi_c = '0;
    if (p_q >= WIDTH'(2) && q_q >= WIDTH'(2))
      phi_c = NW'(p_q - 1'b1) * NW'(q_q - 1'b1);
  end

  assign init_bad = (phi_c == '0) || (e_q == '0) ||
                    (e_q >= phi_c);

  assign quo   = (r1_q != '0) ? r0_q / r1_q : '0;
  assign r_nxt = r0_q - quo * r1_q;
  assign t_nxt = t0_q - $signed({2'b00, quo}) * t1_q;

  // bring a negative coefficient into [1, phi-1] before truncation
  assign d_ext = t0_q[TW-1] ? t0_q + $signed({2'b00, phi_q})
                            : t0_q;
  assign fix_err = err_q || (r0_q != NW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_INIT;
      S_INIT: state_d = init_bad ? S_FIX : S_ITER;
      S_ITER: if (r_nxt == '0) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      q_q       <= '0;
      e_q       <= '0;
      phi_q     <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      err_q     <= 1'b0;
      arm_q     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      OUT_N     <= '0;
      OUT_D     <= '0;
      out_err   <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          out_valid <= 1'b0;
          OUT_N     <= '0;
          OUT_D     <= '0;
          out_err   <= 1'b0;
          busy      <= accept;
          if (accept) begin
            p_q <= IN_P;
            q_q <= IN_Q;
            e_q <= IN_E;
          end
        end
        S_INIT: begin
          phi_q <= phi_c;
          r0_q  <= phi_c;
          r1_q  <= e_q;
          t0_q  <= '0;
          t1_q  <= TW'(1);
          err_q <= init_bad;
        end
        S_ITER: begin
          r0_q <= r1_q;
          r1_q <= r_nxt;
          t0_q <= t1_q;
          t1_q <= t_nxt;
        end
        S_FIX: begin
          out_valid <= 1'b1;
          OUT_N     <= NW'(p_q) * NW'(q_q);
          OUT_D     <= fix_err ? '0 : d_ext[NW-1:0];
          out_err   <= fix_err;
        end
      endcase
    end
  end

endmodule
